// File: rtl/xvga_timing_if.sv
// Raster timing bundle driven by xvga_timing and read by the pixel pipeline.
// The frame_count_out signal is present only when XVGA_FRAME_COUNT_EN is defined.
interface xvga_timing_if;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        blank_out;
    logic        frame_tick_out;
`ifdef XVGA_FRAME_COUNT_EN
    logic [15:0] frame_count_out;

    modport master (
        output hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
               frame_tick_out, frame_count_out
    );
    modport slave (
        input hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
              frame_tick_out, frame_count_out
    );
`else
    modport master (
        output hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
               frame_tick_out
    );
    modport slave (
        input hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
              frame_tick_out
    );
`endif
endinterface

// File: rtl/xvga_timing.sv
// 1024x768@60Hz raster timing generator: pixel/line counters, sync, blank, frame tick.
// Define XVGA_FRAME_COUNT_EN to add the 16-bit frame counter on frame_count_out.
module xvga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic          vclock_in,
    input  logic          reset_in,
    xvga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount, hcount_nxt;
    logic [9:0]  vcount, vcount_nxt;
    logic        hsync, vsync, blank, tick;
    logic        hsync_nxt, vsync_nxt, blank_nxt, tick_nxt;

    always_comb begin
        hcount_nxt = hcount + 11'd1;
        vcount_nxt = vcount;
        if (hcount == H_LAST) begin
            hcount_nxt = '0;
            vcount_nxt = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end
    end

    // Decode from the next counter values so every flag lines up with its pixel.
    always_comb begin
        hsync_nxt = (hcount_nxt >= HS_START) && (hcount_nxt < HS_END);
        vsync_nxt = (vcount_nxt >= VS_START) && (vcount_nxt < VS_END);
        blank_nxt = (hcount_nxt >= H_VIS) || (vcount_nxt >= V_VIS);
        tick_nxt  = (hcount_nxt == '0) && (vcount_nxt == V_VIS);
    end

    always_ff @(posedge vclock_in or posedge reset_in) begin
        if (reset_in) begin
            hcount <= '0;
            vcount <= '0;
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            blank  <= 1'b0;
            tick   <= 1'b0;
        end else begin
            hcount <= hcount_nxt;
            vcount <= vcount_nxt;
            hsync  <= hsync_nxt;
            vsync  <= vsync_nxt;
            blank  <= blank_nxt;
            tick   <= tick_nxt;
        end
    end

    assign vga.hcount_out     = hcount;
    assign vga.vcount_out     = vcount;
    assign vga.hsync_out      = hsync;
    assign vga.vsync_out      = vsync;
    assign vga.blank_out      = blank;
    assign vga.frame_tick_out = tick;

`ifdef XVGA_FRAME_COUNT_EN
    logic [15:0] frame_count;

    // Only written on a tick, so a held value survives between frames.
    always_ff @(posedge vclock_in or posedge reset_in) begin
        if (reset_in) begin
            frame_count <= '0;
        end else if (tick_nxt) begin
            frame_count <= frame_count + 16'd1;
        end
    end

    assign vga.frame_count_out = frame_count;
`endif
endmodule

// File: tb/tb_xvga_timing.sv
// Self-checking bench for xvga_timing using a reduced raster so several frames fit in a short run.
// Define XVGA_FRAME_COUNT_EN to also check the frame counter.
module tb_xvga_timing;
    localparam int HA = 32, HF = 4, HS = 8, HB = 6;
    localparam int VA = 20, VF = 2, VS = 3, VB = 5;
    localparam int HT = HA + HF + HS + HB;   // 50
    localparam int VT = VA + VF + VS + VB;   // 30
    localparam int FRAME = HT * VT;          // 1500
    localparam int TICK_T = VA * HT;         // 1000

    logic vclock_in = 1'b0;
    logic reset_in  = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   check_en = 1'b0;

    int          t;
    logic [15:0] fc_ticks;
    logic [15:0] fc_off = '0;
    int          mh, mv;

    xvga_timing_if vga();

    xvga_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .vclock_in(vclock_in),
        .reset_in (reset_in),
        .vga      (vga)
    );

    always #5 vclock_in = ~vclock_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // Model: raster position is simply the number of clock edges since reset.
    always @(posedge vclock_in or posedge reset_in) begin
        if (reset_in) begin
            t        <= 0;
            fc_ticks <= '0;
        end else begin
            t <= t + 1;
            if (((t + 1) % FRAME) == TICK_T) fc_ticks <= fc_ticks + 16'd1;
        end
    end

    always @(negedge vclock_in) begin
        if (check_en) begin
            mh = t % HT;
            mv = (t / HT) % VT;
            chk("hcount", 32'(vga.hcount_out), 32'(mh));
            chk("vcount", 32'(vga.vcount_out), 32'(mv));
            chk("hsync", 32'(vga.hsync_out), 32'(mh >= HA + HF && mh < HA + HF + HS));
            chk("vsync", 32'(vga.vsync_out), 32'(mv >= VA + VF && mv < VA + VF + VS));
            chk("blank", 32'(vga.blank_out), 32'(mh >= HA || mv >= VA));
            chk("tick", 32'(vga.frame_tick_out), 32'(mh == 0 && mv == VA));
`ifdef XVGA_FRAME_COUNT_EN
            chk("frame_count", 32'(vga.frame_count_out), 32'(16'(fc_ticks + fc_off)));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int blank0, hs_cnt, vs_cnt, ticks, last_tick, found;
        blank0 = 0; hs_cnt = 0; vs_cnt = 0; ticks = 0; last_tick = -1; found = 0;

        reset_in = 1'b1;
        repeat (3) @(posedge vclock_in);
        @(negedge vclock_in);
        check_en = 1'b1;
        chk("rst_hcount", 32'(vga.hcount_out), 0);
        chk("rst_vcount", 32'(vga.vcount_out), 0);
        chk("rst_blank", 32'(vga.blank_out), 0);
        chk("rst_tick", 32'(vga.frame_tick_out), 0);
        reset_in = 1'b0;

        @(posedge vclock_in); #1;
        chk("first_hcount", 32'(vga.hcount_out), 1);
        chk("first_vcount", 32'(vga.vcount_out), 0);
        chk("first_blank", 32'(vga.blank_out), 0);

        for (int i = 1; i <= 3 * FRAME; i++) begin
            if (i > 1) begin
                @(posedge vclock_in); #1;
            end
            if (i <= FRAME) begin
                if (!vga.blank_out) blank0++;
                if (vga.vsync_out) vs_cnt++;
            end
            if (i <= HT && vga.hsync_out) hs_cnt++;
            if (i == 31) chk("blank_before_1st_hblank", 32'(vga.blank_out), 0);
            if (i == 32) chk("blank_at_hactive", 32'(vga.blank_out), 1);
            if (i == 49) chk("line_end_h", 32'(vga.hcount_out), 49);
            if (i == 50) begin
                chk("line_wrap_h", 32'(vga.hcount_out), 0);
                chk("line_wrap_v", 32'(vga.vcount_out), 1);
            end
            if (i == 1499) begin
                chk("frame_end_h", 32'(vga.hcount_out), 49);
                chk("frame_end_v", 32'(vga.vcount_out), 29);
            end
            if (i == 1500) begin
                chk("frame_wrap_h", 32'(vga.hcount_out), 0);
                chk("frame_wrap_v", 32'(vga.vcount_out), 0);
            end
            if (vga.frame_tick_out) begin
                ticks++;
                chk("tick_pos_h", 32'(vga.hcount_out), 0);
                chk("tick_pos_v", 32'(vga.vcount_out), 20);
                if (last_tick < 0) chk("first_tick_time", 32'(i), 1000);
                else chk("tick_spacing", 32'(i - last_tick), 1500);
                last_tick = i;
`ifdef XVGA_FRAME_COUNT_EN
                if (ticks == 1) chk("fc_first", 32'(vga.frame_count_out), 1);
                if (ticks == 2) chk("fc_second", 32'(vga.frame_count_out), 2);
                if (ticks == 3) chk("fc_wrap", 32'(vga.frame_count_out), 0);
`endif
            end
`ifdef XVGA_FRAME_COUNT_EN
            if (i == 3000) begin
                force dut.frame_count = 16'hFFFF;
                fc_off = 16'hFFFF - fc_ticks;
                #1;
                release dut.frame_count;
            end
`endif
        end
        chk("tick_count", 32'(ticks), 3);
        chk("visible_cycles", 32'(blank0), 640);
        chk("hsync_cycles", 32'(hs_cnt), 8);
        chk("vsync_cycles", 32'(vs_cnt), 150);

        // Run to (25,15) of the fourth frame, then reset mid-frame.
        for (int i = 4501; i <= 5275; i++) begin
            @(posedge vclock_in); #1;
        end
        chk("pre_reset_h", 32'(vga.hcount_out), 25);
        chk("pre_reset_v", 32'(vga.vcount_out), 15);
        #1;
        reset_in = 1'b1;
        fc_off   = '0;
        #1;
        chk("async_rst_h", 32'(vga.hcount_out), 0);
        chk("async_rst_v", 32'(vga.vcount_out), 0);
        chk("async_rst_blank", 32'(vga.blank_out), 0);
        chk("async_rst_hsync", 32'(vga.hsync_out), 0);
        chk("async_rst_vsync", 32'(vga.vsync_out), 0);
`ifdef XVGA_FRAME_COUNT_EN
        chk("async_rst_fc", 32'(vga.frame_count_out), 0);
`endif
        repeat (3) @(posedge vclock_in);
        @(negedge vclock_in);
        reset_in = 1'b0;

        for (int i = 1; i <= 1600 && found == 0; i++) begin
            @(posedge vclock_in); #1;
            if (vga.frame_tick_out) begin
                found = 1;
                chk("post_reset_tick_time", 32'(i), 1000);
                chk("post_reset_tick_h", 32'(vga.hcount_out), 0);
                chk("post_reset_tick_v", 32'(vga.vcount_out), 20);
`ifdef XVGA_FRAME_COUNT_EN
                chk("post_reset_fc", 32'(vga.frame_count_out), 1);
`endif
            end
        end
        chk("post_reset_tick_seen", 32'(found), 1);

        @(negedge vclock_in);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
